// File: rtl/lisnoc_router_output_arb.sv
// Wormhole output arbiter: round-robin selection among input ports, locked to the
// winner until its last flit passes. Define LISNOC_ROUTER_OUTPUT_ARB_PKTCNT_EN to add pkt_count.
module lisnoc_router_output_arb #(
   parameter int flit_data_width = 32,
   parameter int flit_type_width = 2,
   parameter int ports           = 5
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic [ports-1:0]                                    request,
   input  logic [ports*(flit_data_width+flit_type_width)-1:0]  flit_i,
   output logic [ports-1:0]                                    read_o,
   output logic [flit_data_width+flit_type_width-1:0]          flit_o,
   output logic                                                valid_o,
   input  logic                                                ready_i
`ifdef LISNOC_ROUTER_OUTPUT_ARB_PKTCNT_EN
   ,
   output logic [15:0]                                         pkt_count
`endif
);

   localparam int flit_width = flit_data_width + flit_type_width;
   localparam int pw         = (ports > 1) ? $clog2(ports) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                state, state_nxt;
   logic [ports-1:0]      grant, grant_nxt;
   logic [pw-1:0]         ptr, ptr_nxt;
   logic [pw-1:0]         win_idx, own_idx;
   logic                  win_found;
   logic [flit_width-1:0] sel_flit;
   logic                  any_read, last;
   int                    cand;

   // round-robin search starting at ptr, wrapping modulo ports
   always_comb begin
      win_idx   = '0;
      win_found = 1'b0;
      cand      = 0;
      for (int i = 0; i < ports; i++) begin
         cand = int'(ptr) + i;
         if (cand >= ports) cand = cand - ports;
         if (!win_found && request[cand]) begin
            win_found = 1'b1;
            win_idx   = pw'(cand);
         end
      end
   end

   always_comb begin
      own_idx = '0;
      for (int i = 0; i < ports; i++)
         if (grant[i]) own_idx = pw'(i);
   end

   assign sel_flit = flit_i[own_idx*flit_width +: flit_width];
   assign last     = sel_flit[flit_data_width+1];

   // reads are suppressed while rst is high so a locked packet is abandoned cleanly
   always_comb begin
      read_o = '0;
      if (state == LOCKED && !rst)
         read_o = grant & request & {ports{~valid_o | ready_i}};
   end

   assign any_read = |read_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         grant <= '0;
         ptr   <= '0;
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         ptr   <= ptr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_nxt          = LOCKED;
               grant_nxt          = '0;
               grant_nxt[win_idx] = 1'b1;
            end
         end
         LOCKED: begin
            if (any_read && last) begin
               state_nxt = IDLE;
               grant_nxt = '0;
               ptr_nxt   = (own_idx == pw'(ports-1)) ? '0 : own_idx + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         flit_o  <= '0;
         valid_o <= 1'b0;
      end else if (any_read) begin
         flit_o  <= sel_flit;
         valid_o <= 1'b1;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

`ifdef LISNOC_ROUTER_OUTPUT_ARB_PKTCNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         pkt_count <= '0;
      else if (any_read && last)
         pkt_count <= pkt_count + 16'd1;
   end
`endif

endmodule
